drive_arbiter: RTL and testbench
================================

# drive_arbiter

Motion controller that owns both wheel drivers and the direction LEDs, and arbitrates between line-tracing steering and obstacle-avoidance requests. When an obstacle is reported, it runs a timed brake → reverse → turn manoeuvre, then hands control back to tracing. It sits between the path-detect / avoidance front ends and the motor-driver pins, and holds the only PWM generator for wheel speed.

## Interface
Parameters:
- PWM_PERIOD, 1000: PWM period in clk cycles
- DUTY_FAST, 800: high cycles per period, fast speed
- DUTY_SLOW, 400: high cycles per period, slow speed; also the manoeuvre speed
- BRAKE_CYC, 50_000: brake duration in cycles
- BACK_CYC, 200_000: reverse duration in cycles
- TURN_CYC, 150_000: turn duration in cycles
- LOST_CYC, 100_000: cycles to keep the last steering after the line is lost

Ports:
- clk, input, 1: system clock
- CR, input, 1: synchronous, active-high reset
- en_tracing, input, 1: 1 = motion enabled
- speed_sel, input, 1: 1 = DUTY_FAST, 0 = DUTY_SLOW (tracing only)
- path_dect, input, 3: {L,C,R} line sensors, 1 = line seen
- avoid_req, input, 2: 00 none, 01 obstacle (turn left), 10 obstacle (turn right), 11 blocked (turn right, double reverse)
- ctrl_wheel_1, output, 2: left wheel, 10 fwd / 01 rev / 00 stop
- ctrl_wheel_2, output, 2: right wheel, same coding
- speed_wheel_1, output, 1: left wheel PWM
- speed_wheel_2, output, 1: right wheel PWM
- led_direction, output, 4: one-hot {fwd, left, right, back}; 0000 = stopped
- busy, output, 1: 1 during BRAKE, REVERSE or TURN

## Operation
States: IDLE, TRACE, BRAKE, REVERSE, TURN. One shared down-counter `tmr`, sized for the largest of 2·BACK_CYC, LOST_CYC and TURN_CYC.

Transitions:
- IDLE → TRACE when en_tracing = 1.
- TRACE → BRAKE when avoid_req ≠ 00. On entry, latch turn_dir (01 → left, else right) and dbl = (avoid_req == 11); load tmr = BRAKE_CYC-1.
- BRAKE → REVERSE at tmr = 0; load BACK_CYC-1, or 2·BACK_CYC-1 if dbl.
- REVERSE → TURN at tmr = 0; load TURN_CYC-1.
- TURN → TRACE at tmr = 0, whatever avoid_req is. If avoid_req is still non-zero, the next cycle in TRACE re-enters BRAKE.
- en_tracing = 0 in any state → IDLE on the next edge. This beats the timer and avoid_req.
- avoid_req changes during BRAKE, REVERSE or TURN are ignored.

Per-state outputs (wheel_1 / wheel_2, LED):
- IDLE and BRAKE: 00/00, LED 0000, duty 0.
- REVERSE: 01/01, back, DUTY_SLOW.
- TURN left: 00/10, left. TURN right: 10/00, right. Both at DUTY_SLOW.
- TRACE, by path_dect:
  - 010, 111 or 101: 10/10, fwd.
  - 100 or 110: 00/10, left.
  - 001 or 011: 10/00, right.
  - 000: repeat the last non-000 decision for LOST_CYC cycles, then 00/00 with LED 0000 until a non-000 pattern returns. The lost-line counter reloads whenever the pattern is non-000.
  - Duty in TRACE: speed_sel ? DUTY_FAST : DUTY_SLOW.
  - The last decision resets to fwd.

PWM:
- pcnt counts 0..PWM_PERIOD-1 and wraps.
- speed_wheel_x = (pcnt < duty_act) && that wheel's ctrl ≠ 00.
- duty_act loads the requested duty only when pcnt = PWM_PERIOD-1, so there are no runt pulses. The exception is a request of 0, which applies immediately.

## Timing
- All outputs are registered. ctrl, LED and busy reflect inputs sampled at edge n from edge n+1.
- The manoeuvre lasts exactly BRAKE_CYC + BACK_CYC(×2) + TURN_CYC cycles from the first BRAKE cycle to the first TRACE cycle.
- Reset (CR = 1, sampled on the clk edge) values:
  - state = IDLE, all ctrl = 00, speed = 0, LED = 0000, busy = 0.
  - pcnt, tmr, duty_act, lost counter and last decision all cleared (last decision = fwd).
- Reset mid-manoeuvre aborts it; nothing is resumed.
- If en_tracing and avoid_req both assert on the same cycle from IDLE, go to TRACE first and enter BRAKE one cycle later.

## Structure
- Shared package `smartcar_pkg`:
  - state enum
  - wheel codes FWD = 2'b10, REV = 2'b01, STOP = 2'b00
  - LED one-hot constants
  - avoid_req encodings
- Sub-module `pwm_gen`: parameter PERIOD; ports clk, CR, duty, en, pwm. Holds the period-boundary duty update. Instantiate it once and gate its output per wheel with that wheel's ctrl ≠ 00.

## Test plan
Bench parameters: PWM_PERIOD = 10, BRAKE_CYC = 4, BACK_CYC = 6, TURN_CYC = 5, LOST_CYC = 8.
- Reset with CR = 1 while inputs toggle → every output 0, busy = 0, state IDLE, held until CR falls.
- en_tracing = 1, speed_sel = 1, path_dect = 010 → next cycle ctrl 10/10, LED fwd. Both PWMs high 8 of every 10 cycles, starting at a period boundary.
- path_dect 100 → 000 held 12 cycles → left steering for 8 cycles, then 00/00 with LED 0000. Applying 001 → right on the next cycle.
- In TRACE, avoid_req = 01 for 1 cycle → busy for 15 cycles: brake 4, reverse 6 at duty 4/10, turn left 5 (00/10). Then TRACE.
- avoid_req = 11 → reverse lasts 12 cycles and the turn is right. Drop en_tracing mid-reverse → IDLE next cycle, all outputs 0.
- avoid_req held at 10 through the end of TURN → exactly one TRACE cycle, then BRAKE again.

Source files
------------

// File: rtl/smartcar_pkg.sv
// smartcar_pkg: shared types and constants for the motion controller.
//   state_t      - arbiter FSM states
//   dec_t        - line-tracing steering decision
//   drive_t      - one wheel-command/LED bundle
//   FWD/REV/STOP - wheel driver codes
//   LED_*        - one-hot direction LEDs {fwd, left, right, back}
//   AVOID_*      - avoid_req encodings
package smartcar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRACE,
        ST_BRAKE,
        ST_REVERSE,
        ST_TURN
    } state_t;

    typedef enum logic [1:0] {
        DEC_FWD,
        DEC_LEFT,
        DEC_RIGHT
    } dec_t;

    localparam logic [1:0] FWD  = 2'b10;
    localparam logic [1:0] REV  = 2'b01;
    localparam logic [1:0] STOP = 2'b00;

    localparam logic [3:0] LED_OFF   = 4'b0000;
    localparam logic [3:0] LED_FWD   = 4'b1000;
    localparam logic [3:0] LED_LEFT  = 4'b0100;
    localparam logic [3:0] LED_RIGHT = 4'b0010;
    localparam logic [3:0] LED_BACK  = 4'b0001;

    localparam logic [1:0] AVOID_NONE    = 2'b00;
    localparam logic [1:0] AVOID_LEFT    = 2'b01;
    localparam logic [1:0] AVOID_RIGHT   = 2'b10;
    localparam logic [1:0] AVOID_BLOCKED = 2'b11;

    typedef struct packed {
        logic [1:0] wheel_1;
        logic [1:0] wheel_2;
        logic [3:0] led;
    } drive_t;

    localparam drive_t DRIVE_STOP = '{wheel_1: STOP, wheel_2: STOP, led: LED_OFF};

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Steering for a non-zero {L,C,R} pattern; 000 is handled by the caller.
    function automatic dec_t path_decision(input logic [2:0] path);
        case (path)
            3'b100, 3'b110: return DEC_LEFT;
            3'b001, 3'b011: return DEC_RIGHT;
            default:        return DEC_FWD;
        endcase
    endfunction

    // Turning left stops the left wheel and drives the right one, and vice versa.
    function automatic drive_t decision_drive(input dec_t dec);
        case (dec)
            DEC_LEFT:  return '{wheel_1: STOP, wheel_2: FWD,  led: LED_LEFT};
            DEC_RIGHT: return '{wheel_1: FWD,  wheel_2: STOP, led: LED_RIGHT};
            default:   return '{wheel_1: FWD,  wheel_2: FWD,  led: LED_FWD};
        endcase
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: single PWM generator shared by both wheels.
//   clk  - system clock
//   CR   - synchronous active-high reset
//   duty - requested high cycles per period
//   en   - output enable
//   pwm  - (pcnt < duty_act) && en
// A non-zero duty request is only taken at the end of a period so a
// running period is never cut short; a zero request stops output at once.
module pwm_gen #(
    parameter int PERIOD = 1000
) (
    input  logic                         clk,
    input  logic                         CR,
    input  logic [$clog2(PERIOD+1)-1:0]  duty,
    input  logic                         en,
    output logic                         pwm
);

    localparam int W = $clog2(PERIOD + 1);
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] pcnt;
    logic [W-1:0] duty_act;

    // NOTE: sequential state is assigned with <= so every flop updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (CR) begin
            pcnt     <= '0;
            duty_act <= '0;
        end else begin
            pcnt <= (pcnt == LAST) ? '0 : pcnt + W'(1);
            if (duty == '0) begin
                duty_act <= '0;
            end else if (pcnt == LAST) begin
                duty_act <= duty;
            end
        end
    end

    assign pwm = en && (pcnt < duty_act);

endmodule

// File: rtl/drive_arbiter.sv
// drive_arbiter: owns both wheel drivers and the direction LEDs, arbitrating
// between line tracing and a timed brake -> reverse -> turn avoidance manoeuvre.
//   clk            - system clock
//   CR             - synchronous active-high reset
//   en_tracing     - 1 = motion enabled; 0 forces IDLE on the next edge
//   speed_sel      - tracing speed, 1 = DUTY_FAST, 0 = DUTY_SLOW
//   path_dect      - {L,C,R} line sensors
//   avoid_req      - obstacle request (see AVOID_* in smartcar_pkg)
//   ctrl_wheel_1/2 - left/right wheel commands (10 fwd, 01 rev, 00 stop)
//   speed_wheel_1/2- per-wheel PWM, silenced while that wheel is stopped
//   led_direction  - one-hot {fwd, left, right, back}
//   busy           - high during BRAKE, REVERSE and TURN
// Output registers are loaded from the next-state decode, so ctrl/LED/busy
// line up cycle-for-cycle with the state register.
module drive_arbiter
    import smartcar_pkg::*;
#(
    parameter int PWM_PERIOD = 1000,
    parameter int DUTY_FAST  = 800,
    parameter int DUTY_SLOW  = 400,
    parameter int BRAKE_CYC  = 50_000,
    parameter int BACK_CYC   = 200_000,
    parameter int TURN_CYC   = 150_000,
    parameter int LOST_CYC   = 100_000
) (
    input  logic       clk,
    input  logic       CR,
    input  logic       en_tracing,
    input  logic       speed_sel,
    input  logic [2:0] path_dect,
    input  logic [1:0] avoid_req,
    output logic [1:0] ctrl_wheel_1,
    output logic [1:0] ctrl_wheel_2,
    output logic       speed_wheel_1,
    output logic       speed_wheel_2,
    output logic [3:0] led_direction,
    output logic       busy
);

    localparam int TMR_MAX = max2(max2(2 * BACK_CYC, LOST_CYC), max2(TURN_CYC, BRAKE_CYC));
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int LOST_W  = $clog2(LOST_CYC + 1);
    localparam int DUTY_W  = $clog2(PWM_PERIOD + 1);

    state_t              state_q, state_nxt;
    logic [TMR_W-1:0]    tmr_q;
    logic                turn_left_q;
    logic                dbl_q;
    logic [LOST_W-1:0]   lost_q, lost_nxt;
    dec_t                last_dec_q, last_dec_nxt;
    drive_t              trace_drv;
    drive_t              drv_nxt;
    logic                busy_nxt;
    logic [DUTY_W-1:0]   duty_nxt;
    logic                pwm;

    // State register.
    always_ff @(posedge clk) begin
        if (CR) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic; dropping en_tracing wins over the timer and avoid_req.
    always_comb begin
        state_nxt = state_q;
        if (!en_tracing) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_nxt = ST_TRACE;
                ST_TRACE:   if (avoid_req != AVOID_NONE) state_nxt = ST_BRAKE;
                ST_BRAKE:   if (tmr_q == '0) state_nxt = ST_REVERSE;
                ST_REVERSE: if (tmr_q == '0) state_nxt = ST_TURN;
                ST_TURN:    if (tmr_q == '0) state_nxt = ST_TRACE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    // Line-tracing decision: a lost line keeps the last steering for
    // LOST_CYC cycles, then stops until a pattern comes back.
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        trace_drv    = DRIVE_STOP;
        lost_nxt     = lost_q;
        last_dec_nxt = last_dec_q;
        if (path_dect != 3'b000) begin
            last_dec_nxt = path_decision(path_dect);
            lost_nxt     = LOST_W'(LOST_CYC);
            trace_drv    = decision_drive(last_dec_nxt);
        end else if (lost_q != '0) begin
            lost_nxt  = lost_q - LOST_W'(1);
            trace_drv = decision_drive(last_dec_q);
        end
    end

    // Output decode from the state being entered.
    always_comb begin
        drv_nxt  = DRIVE_STOP;
        busy_nxt = 1'b0;
        duty_nxt = '0;
        case (state_nxt)
            ST_TRACE: begin
                drv_nxt  = trace_drv;
                duty_nxt = speed_sel ? DUTY_W'(DUTY_FAST) : DUTY_W'(DUTY_SLOW);
            end
            ST_BRAKE: begin
                busy_nxt = 1'b1;
            end
            ST_REVERSE: begin
                drv_nxt  = '{wheel_1: REV, wheel_2: REV, led: LED_BACK};
                busy_nxt = 1'b1;
                duty_nxt = DUTY_W'(DUTY_SLOW);
            end
            ST_TURN: begin
                drv_nxt  = decision_drive(turn_left_q ? DEC_LEFT : DEC_RIGHT);
                busy_nxt = 1'b1;
                duty_nxt = DUTY_W'(DUTY_SLOW);
            end
            default: ;
        endcase
    end

    // Shared timer: loaded on each state change, then counts down to 0.
    always_ff @(posedge clk) begin
        if (CR) begin
            tmr_q <= '0;
        end else if (state_nxt != state_q) begin
            case (state_nxt)
                ST_BRAKE:   tmr_q <= TMR_W'(BRAKE_CYC - 1);
                ST_REVERSE: tmr_q <= dbl_q ? TMR_W'(2 * BACK_CYC - 1) : TMR_W'(BACK_CYC - 1);
                ST_TURN:    tmr_q <= TMR_W'(TURN_CYC - 1);
                default:    tmr_q <= '0;
            endcase
        end else if (tmr_q != '0) begin
            tmr_q <= tmr_q - TMR_W'(1);
        end
    end

    // Manoeuvre parameters are captured once on BRAKE entry; later
    // avoid_req changes do not affect the running manoeuvre.
    always_ff @(posedge clk) begin
        if (CR) begin
            turn_left_q <= 1'b0;
            dbl_q       <= 1'b0;
        end else if (state_q == ST_TRACE && state_nxt == ST_BRAKE) begin
            turn_left_q <= (avoid_req == AVOID_LEFT);
            dbl_q       <= (avoid_req == AVOID_BLOCKED);
        end
    end

    // Lost-line tracking only advances while tracing.
    always_ff @(posedge clk) begin
        if (CR) begin
            lost_q     <= '0;
            last_dec_q <= DEC_FWD;
        end else if (state_nxt == ST_TRACE) begin
            lost_q     <= lost_nxt;
            last_dec_q <= last_dec_nxt;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (CR) begin
            ctrl_wheel_1  <= STOP;
            ctrl_wheel_2  <= STOP;
            led_direction <= LED_OFF;
            busy          <= 1'b0;
        end else begin
            ctrl_wheel_1  <= drv_nxt.wheel_1;
            ctrl_wheel_2  <= drv_nxt.wheel_2;
            led_direction <= drv_nxt.led;
            busy          <= busy_nxt;
        end
    end

    // The duty request goes straight from the decode so duty_act and the
    // wheel commands change on the same edge.
    pwm_gen #(
        .PERIOD (PWM_PERIOD)
    ) u_pwm_gen (
        .clk  (clk),
        .CR   (CR),
        .duty (duty_nxt),
        .en   (state_q != ST_IDLE),
        .pwm  (pwm)
    );

    assign speed_wheel_1 = pwm && (ctrl_wheel_1 != STOP);
    assign speed_wheel_2 = pwm && (ctrl_wheel_2 != STOP);

endmodule

// File: tb/tb_drive_arbiter.sv
// tb_drive_arbiter: table-driven bench for drive_arbiter. Each vector holds
// the inputs for one clock and the expected state/outputs after that edge;
// expected results go into a scoreboard queue on drive and are popped and
// compared #1 after the edge. PWM expectations come from a small period model.
`timescale 1ns/1ps
module tb_drive_arbiter;
    import smartcar_pkg::*;

    localparam int PWM_PERIOD = 10;
    localparam int DUTY_FAST  = 8;
    localparam int DUTY_SLOW  = 4;
    localparam int BRAKE_CYC  = 4;
    localparam int BACK_CYC   = 6;
    localparam int TURN_CYC   = 5;
    localparam int LOST_CYC   = 8;

    logic       clk = 1'b0;
    logic       CR;
    logic       en_tracing;
    logic       speed_sel;
    logic [2:0] path_dect;
    logic [1:0] avoid_req;
    logic [1:0] ctrl_wheel_1;
    logic [1:0] ctrl_wheel_2;
    logic       speed_wheel_1;
    logic       speed_wheel_2;
    logic [3:0] led_direction;
    logic       busy;

    drive_arbiter #(
        .PWM_PERIOD (PWM_PERIOD),
        .DUTY_FAST  (DUTY_FAST),
        .DUTY_SLOW  (DUTY_SLOW),
        .BRAKE_CYC  (BRAKE_CYC),
        .BACK_CYC   (BACK_CYC),
        .TURN_CYC   (TURN_CYC),
        .LOST_CYC   (LOST_CYC)
    ) dut (
        .clk           (clk),
        .CR            (CR),
        .en_tracing    (en_tracing),
        .speed_sel     (speed_sel),
        .path_dect     (path_dect),
        .avoid_req     (avoid_req),
        .ctrl_wheel_1  (ctrl_wheel_1),
        .ctrl_wheel_2  (ctrl_wheel_2),
        .speed_wheel_1 (speed_wheel_1),
        .speed_wheel_2 (speed_wheel_2),
        .led_direction (led_direction),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cr;
        logic       en;
        logic       spd;
        logic [2:0] path;
        logic [1:0] avoid;
        state_t     st;
        logic [1:0] c1;
        logic [1:0] c2;
        logic [3:0] led;
    } vec_t;

    typedef struct {
        int         idx;
        logic [1:0] c1;
        logic [1:0] c2;
        logic [3:0] led;
        logic       busy;
        logic       s1;
        logic       s2;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_no = 0;
    int   bpc    = 0;
    int   bduty  = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic add(input int n, input logic cr, input logic en, input logic spd,
                       input logic [2:0] path, input logic [1:0] avoid, input state_t st,
                       input logic [1:0] c1, input logic [1:0] c2, input logic [3:0] led);
        vec_t v;
        v.cr = cr; v.en = en; v.spd = spd; v.path = path; v.avoid = avoid;
        v.st = st; v.c1 = c1; v.c2 = c2; v.led = led;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic add_fwd(input int n, input logic spd);
        add(n, 1'b0, 1'b1, spd, 3'b010, 2'b00, ST_TRACE, FWD, FWD, LED_FWD);
    endtask

    // Entry cycle (TRACE with first_avoid -> BRAKE) plus the rest of the manoeuvre.
    task automatic add_man(input logic [1:0] first_avoid, input logic [1:0] rest_avoid,
                           input bit left, input bit dbl);
        add(1, 1'b0, 1'b1, 1'b1, 3'b010, first_avoid, ST_BRAKE, STOP, STOP, LED_OFF);
        add(BRAKE_CYC - 1, 1'b0, 1'b1, 1'b1, 3'b010, rest_avoid, ST_BRAKE, STOP, STOP, LED_OFF);
        add(dbl ? 2 * BACK_CYC : BACK_CYC, 1'b0, 1'b1, 1'b1, 3'b010, rest_avoid,
            ST_REVERSE, REV, REV, LED_BACK);
        if (left)
            add(TURN_CYC, 1'b0, 1'b1, 1'b1, 3'b010, rest_avoid, ST_TURN, STOP, FWD, LED_LEFT);
        else
            add(TURN_CYC, 1'b0, 1'b1, 1'b1, 3'b010, rest_avoid, ST_TURN, FWD, STOP, LED_RIGHT);
    endtask

    function automatic int duty_of(input state_t st, input logic spd);
        case (st)
            ST_TRACE:            return spd ? DUTY_FAST : DUTY_SLOW;
            ST_REVERSE, ST_TURN: return DUTY_SLOW;
            default:             return 0;
        endcase
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        exp_t got;
        int   req;
        CR         = v.cr;
        en_tracing = v.en;
        speed_sel  = v.spd;
        path_dect  = v.path;
        avoid_req  = v.avoid;

        // PWM reference: duty taken at period end, zero applies at once.
        req = duty_of(v.st, v.spd);
        if (v.cr) begin
            bpc   = 0;
            bduty = 0;
        end else begin
            if (req == 0) bduty = 0;
            else if (bpc == PWM_PERIOD - 1) bduty = req;
            bpc = (bpc + 1) % PWM_PERIOD;
        end

        e.idx  = vec_no;
        e.c1   = v.c1;
        e.c2   = v.c2;
        e.led  = v.led;
        e.busy = (v.st == ST_BRAKE || v.st == ST_REVERSE || v.st == ST_TURN);
        e.s1   = (bpc < bduty) && (v.c1 != STOP);
        e.s2   = (bpc < bduty) && (v.c2 != STOP);
        exp_q.push_back(e);
        vec_no++;

        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check($sformatf("v%0d ctrl_wheel_1", got.idx), {6'd0, ctrl_wheel_1}, {6'd0, got.c1});
        check($sformatf("v%0d ctrl_wheel_2", got.idx), {6'd0, ctrl_wheel_2}, {6'd0, got.c2});
        check($sformatf("v%0d led_direction", got.idx), {4'd0, led_direction}, {4'd0, got.led});
        check($sformatf("v%0d busy", got.idx), {7'd0, busy}, {7'd0, got.busy});
        check($sformatf("v%0d speed_wheel_1", got.idx), {7'd0, speed_wheel_1}, {7'd0, got.s1});
        check($sformatf("v%0d speed_wheel_2", got.idx), {7'd0, speed_wheel_2}, {7'd0, got.s2});
    endtask

    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
        vecs.delete();
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        CR = 1'b1; en_tracing = 1'b0; speed_sel = 1'b0; path_dect = 3'b000; avoid_req = 2'b00;

        // Table: reset with toggling inputs, then tracing patterns.
        add(1, 1'b1, 1'b1, 1'b1, 3'b010, 2'b11, ST_IDLE, STOP, STOP, LED_OFF);
        add(1, 1'b1, 1'b0, 1'b0, 3'b101, 2'b01, ST_IDLE, STOP, STOP, LED_OFF);
        add(1, 1'b1, 1'b1, 1'b0, 3'b000, 2'b10, ST_IDLE, STOP, STOP, LED_OFF);
        add(2, 1'b0, 1'b0, 1'b1, 3'b010, 2'b00, ST_IDLE, STOP, STOP, LED_OFF);
        add_fwd(25, 1'b1);
        add(1, 1'b0, 1'b1, 1'b1, 3'b100, 2'b00, ST_TRACE, STOP, FWD, LED_LEFT);
        add(LOST_CYC, 1'b0, 1'b1, 1'b1, 3'b000, 2'b00, ST_TRACE, STOP, FWD, LED_LEFT);
        add(4, 1'b0, 1'b1, 1'b1, 3'b000, 2'b00, ST_TRACE, STOP, STOP, LED_OFF);
        add(1, 1'b0, 1'b1, 1'b1, 3'b001, 2'b00, ST_TRACE, FWD, STOP, LED_RIGHT);
        add(1, 1'b0, 1'b1, 1'b1, 3'b011, 2'b00, ST_TRACE, FWD, STOP, LED_RIGHT);
        add(1, 1'b0, 1'b1, 1'b1, 3'b110, 2'b00, ST_TRACE, STOP, FWD, LED_LEFT);
        add(1, 1'b0, 1'b1, 1'b1, 3'b111, 2'b00, ST_TRACE, FWD, FWD, LED_FWD);
        add(1, 1'b0, 1'b1, 1'b1, 3'b101, 2'b00, ST_TRACE, FWD, FWD, LED_FWD);
        add_fwd(3, 1'b1);
        add_fwd(20, 1'b0);
        run_table();

        // Single obstacle, turn left: 4 brake + 6 reverse + 5 turn.
        add_fwd(2, 1'b1);
        add_man(AVOID_LEFT, AVOID_NONE, 1'b1, 1'b0);
        add_fwd(12, 1'b1);
        // Blocked: double reverse, turn right.
        add_man(AVOID_BLOCKED, AVOID_NONE, 1'b0, 1'b1);
        add_fwd(3, 1'b1);
        run_table();

        // Drop en_tracing mid-reverse.
        add(1, 1'b0, 1'b1, 1'b1, 3'b010, AVOID_BLOCKED, ST_BRAKE, STOP, STOP, LED_OFF);
        add(BRAKE_CYC - 1, 1'b0, 1'b1, 1'b1, 3'b010, AVOID_NONE, ST_BRAKE, STOP, STOP, LED_OFF);
        add(5, 1'b0, 1'b1, 1'b1, 3'b010, AVOID_NONE, ST_REVERSE, REV, REV, LED_BACK);
        add(3, 1'b0, 1'b0, 1'b1, 3'b010, AVOID_NONE, ST_IDLE, STOP, STOP, LED_OFF);
        // en_tracing and avoid_req together from IDLE, request held through TURN.
        add(1, 1'b0, 1'b1, 1'b1, 3'b010, AVOID_RIGHT, ST_TRACE, FWD, FWD, LED_FWD);
        add_man(AVOID_RIGHT, AVOID_RIGHT, 1'b0, 1'b0);
        add(1, 1'b0, 1'b1, 1'b1, 3'b010, AVOID_RIGHT, ST_TRACE, FWD, FWD, LED_FWD);
        add_man(AVOID_RIGHT, AVOID_NONE, 1'b0, 1'b0);
        add_fwd(4, 1'b1);
        // Reset mid-manoeuvre aborts it.
        add(1, 1'b0, 1'b1, 1'b1, 3'b010, AVOID_LEFT, ST_BRAKE, STOP, STOP, LED_OFF);
        add(1, 1'b0, 1'b1, 1'b1, 3'b010, AVOID_NONE, ST_BRAKE, STOP, STOP, LED_OFF);
        add(2, 1'b1, 1'b1, 1'b1, 3'b010, AVOID_NONE, ST_IDLE, STOP, STOP, LED_OFF);
        add_fwd(14, 1'b1);
        run_table();

        check("scoreboard drained", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
